// File: rtl/servo_capture_pkg.sv
// rtl/servo_capture_pkg.sv - shared constants, state encoding and helpers for servo_capture
package servo_capture_pkg;

  localparam logic [7:0] ADDR_WIDTH  = 8'h00;
  localparam logic [7:0] ADDR_PERIOD = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_COUNT  = 8'h0C;

  localparam int STATUS_VALID   = 0;
  localparam int STATUS_OVERRUN = 1;
  localparam int STATUS_TIMEOUT = 2;

  // Nominal servo frame; losing the signal for two frames counts as a timeout.
  localparam int unsigned SERVO_PERIOD    = 2000000;
  localparam int unsigned DEFAULT_TIMEOUT = 2 * SERVO_PERIOD;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_HIGH = 2'd1,
    CAP_LOW  = 2'd2
  } cap_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage

// File: rtl/servo_capture_pwm_edge_sync.sv
// rtl/servo_capture_pwm_edge_sync.sv - pwm_in synchronizer with history flop and edge pulses
module servo_capture_pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic pclk,
  input  logic reset,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge pclk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/servo_capture.sv
// rtl/servo_capture.sv - measures high time and period of a servo PWM input, bus-readable
module servo_capture
  import servo_capture_pkg::*;
#(
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        bus_write_en,
  input  logic        bus_read_en,
  input  logic        capture_en,
  input  logic [7:0]  bus_addr,
  input  logic [31:0] bus_write_data,
  input  logic        pwm_in,
  output logic [31:0] bus_read_data,
  output logic        sample_irq
);

  localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT);

  logic       sync_level;
  logic       rise;
  logic       fall;

  cap_state_t  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] high_cap_q, high_cap_d;
  logic [31:0] width_q, period_q;
  logic        valid_q, overrun_q, timeout_q;
  logic        capture, timeout_evt;
  logic        status_wr;
  logic [2:0]  status_clr;
  logic        unused_inputs;

  servo_capture_pwm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .pclk  (pclk),
    .reset (reset),
    .pwm_in(pwm_in),
    .level (sync_level),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q    <= CAP_IDLE;
      cnt_q      <= '0;
      high_cap_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_cap_q <= high_cap_d;
    end
  end

  // A rise in LOW always completes the sample, even on the cycle the counter hits TIMEOUT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    high_cap_d  = high_cap_q;
    capture     = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = CAP_HIGH;
          cnt_d   = 32'd1;
        end
      end
      CAP_HIGH: begin
        cnt_d = sat_inc(cnt_q, TIMEOUT_CNT);
        if (fall) begin
          state_d    = CAP_LOW;
          high_cap_d = cnt_q;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d     = CAP_IDLE;
          cnt_d       = '0;
          timeout_evt = 1'b1;
        end
      end
      CAP_LOW: begin
        cnt_d = sat_inc(cnt_q, TIMEOUT_CNT);
        if (rise) begin
          state_d = CAP_HIGH;
          cnt_d   = 32'd1;
          capture = 1'b1;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d     = CAP_IDLE;
          cnt_d       = '0;
          timeout_evt = 1'b1;
        end
      end
      default: begin
        state_d = CAP_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign status_wr  = bus_write_en & capture_en & (bus_addr == ADDR_STATUS);
  assign status_clr = status_wr ? bus_write_data[2:0] : 3'b000;

  // Set terms are OR-ed after the clear so a same-cycle event survives a W1C.
  always_ff @(posedge pclk) begin
    if (reset) begin
      width_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (capture) begin
        width_q  <= high_cap_q;
        period_q <= cnt_q;
      end
      valid_q   <= (valid_q   & ~status_clr[STATUS_VALID])   | capture;
      overrun_q <= (overrun_q & ~status_clr[STATUS_OVERRUN]) | (capture & valid_q);
      timeout_q <= (timeout_q & ~status_clr[STATUS_TIMEOUT]) | timeout_evt;
    end
  end

  always_comb begin
    bus_read_data = '0;
    if (bus_read_en && capture_en) begin
      case (bus_addr)
        ADDR_WIDTH:  bus_read_data = width_q;
        ADDR_PERIOD: bus_read_data = period_q;
        ADDR_STATUS: bus_read_data = {29'd0, timeout_q, overrun_q, valid_q};
        ADDR_COUNT:  bus_read_data = cnt_q;
        default:     bus_read_data = '0;
      endcase
    end
  end

  assign sample_irq = valid_q;

  assign unused_inputs = ^{bus_write_data[31:3], sync_level};

endmodule

// File: tb/tb_servo_capture.sv
// tb/tb_servo_capture.sv - scoreboard bench for servo_capture with scaled-down timing
module tb_servo_capture;

  localparam int unsigned TB_TIMEOUT = 400;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_write_en = 1'b0;
  logic        bus_read_en = 1'b0;
  logic        capture_en = 1'b1;
  logic [7:0]  bus_addr = 8'h00;
  logic [31:0] bus_write_data = 32'h0;
  logic        pwm_in = 1'b0;
  logic [31:0] bus_read_data;
  logic        sample_irq;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];

  servo_capture #(
    .TIMEOUT    (TB_TIMEOUT),
    .SYNC_STAGES(2)
  ) dut (
    .pclk          (pclk),
    .reset         (reset),
    .bus_write_en  (bus_write_en),
    .bus_read_en   (bus_read_en),
    .capture_en    (capture_en),
    .bus_addr      (bus_addr),
    .bus_write_data(bus_write_data),
    .pwm_in        (pwm_in),
    .bus_read_data (bus_read_data),
    .sample_irq    (sample_irq)
  );

  always #5 pclk = ~pclk;

  // Monitor: every read strobe presents a response that is checked against the queue head.
  always @(negedge pclk) begin
    if (bus_read_en) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got data=%h irq=%b with no expectation queued",
                 bus_read_data, sample_irq);
      end else begin
        e = sb_q.pop_front();
        if (bus_read_data !== e.data || sample_irq !== e.irq) begin
          errors++;
          $display("FAIL %s: got data=%h irq=%b expected data=%h irq=%b",
                   e.name, bus_read_data, sample_irq, e.data, e.irq);
        end
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_read(input string name, input logic [7:0] addr, input logic [31:0] exp_data,
                         input logic exp_irq, input logic en);
    exp_t e;
    e.name = name;
    e.data = exp_data;
    e.irq  = exp_irq;
    sb_q.push_back(e);
    bus_addr    = addr;
    capture_en  = en;
    bus_read_en = 1'b1;
    tick();
    bus_read_en = 1'b0;
    capture_en  = 1'b1;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data);
    bus_addr       = addr;
    bus_write_data = data;
    bus_write_en   = 1'b1;
    tick();
    bus_write_en   = 1'b0;
    bus_write_data = 32'h0;
  endtask

  task automatic run_period(input int high, input int period);
    pwm_in = 1'b1;
    repeat (high) tick();
    pwm_in = 1'b0;
    repeat (period - high) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();

    do_read("reset_width",  8'h00, 32'd0, 1'b0, 1'b1);
    do_read("reset_period", 8'h04, 32'd0, 1'b0, 1'b1);
    do_read("reset_status", 8'h08, 32'd0, 1'b0, 1'b1);
    do_read("reset_count",  8'h0C, 32'd0, 1'b0, 1'b1);

    // Two rises give the first sample.
    run_period(15, 200);
    fork
      run_period(15, 200);
      begin
        repeat (40) tick();
        do_read("first_width",  8'h00, 32'd15,  1'b1, 1'b1);
        do_read("first_period", 8'h04, 32'd200, 1'b1, 1'b1);
        do_read("first_status", 8'h08, 32'h1,   1'b1, 1'b1);
      end
    join

    fork
      run_period(15, 200);
      begin
        repeat (40) tick();
        do_read("overrun_status", 8'h08, 32'h3, 1'b1, 1'b1);
        do_write(8'h08, 32'h2);
        do_read("overrun_cleared", 8'h08, 32'h1, 1'b1, 1'b1);
      end
    join

    // Input stays low past TIMEOUT.
    repeat (TB_TIMEOUT + 20) tick();
    do_read("timeout_status", 8'h08, 32'h5,   1'b1, 1'b1);
    do_read("timeout_width",  8'h00, 32'd15,  1'b1, 1'b1);
    do_read("timeout_period", 8'h04, 32'd200, 1'b1, 1'b1);
    do_read("timeout_count",  8'h0C, 32'd0,   1'b1, 1'b1);
    do_write(8'h08, 32'h7);
    do_read("all_cleared", 8'h08, 32'h0, 1'b0, 1'b1);

    run_period(30, 250);
    fork
      run_period(30, 250);
      begin
        repeat (40) tick();
        do_read("fresh_width",  8'h00, 32'd30,  1'b1, 1'b1);
        do_read("fresh_period", 8'h04, 32'd250, 1'b1, 1'b1);
        do_read("fresh_status", 8'h08, 32'h1,   1'b1, 1'b1);
      end
    join

    // Clear valid on the exact edge the capture lands (two sync flops + history).
    fork
      run_period(30, 250);
      begin
        repeat (2) tick();
        bus_addr       = 8'h08;
        bus_write_data = 32'h1;
        bus_write_en   = 1'b1;
        tick();
        bus_write_en   = 1'b0;
        bus_write_data = 32'h0;
        repeat (40) tick();
        do_read("race_status", 8'h08, 32'h3,   1'b1, 1'b1);
        do_read("race_period", 8'h04, 32'd250, 1'b1, 1'b1);
        do_write(8'h08, 32'h3);
        do_read("race_cleared", 8'h08, 32'h0, 1'b0, 1'b1);
      end
    join

    // Reset in the middle of a high phase.
    pwm_in = 1'b1;
    repeat (50) tick();
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
    do_read("midreset_width",  8'h00, 32'd0, 1'b0, 1'b1);
    do_read("midreset_period", 8'h04, 32'd0, 1'b0, 1'b1);
    do_read("midreset_status", 8'h08, 32'd0, 1'b0, 1'b1);
    do_read("midreset_count",  8'h0C, 32'd0, 1'b0, 1'b1);

    fork
      run_period(20, 150);
      begin
        repeat (40) tick();
        do_read("one_rise_status", 8'h08, 32'h0, 1'b0, 1'b1);
      end
    join
    fork
      run_period(20, 150);
      begin
        repeat (40) tick();
        do_read("post_reset_width",  8'h00, 32'd20,  1'b1, 1'b1);
        do_read("post_reset_period", 8'h04, 32'd150, 1'b1, 1'b1);
        do_read("post_reset_status", 8'h08, 32'h1,   1'b1, 1'b1);
      end
    join

    // Minimum-length pulses.
    repeat (3) run_period(2, 10);
    do_read("short_width",  8'h00, 32'd2,  1'b1, 1'b1);
    do_read("short_period", 8'h04, 32'd10, 1'b1, 1'b1);
    do_read("short_status", 8'h08, 32'h3,  1'b1, 1'b1);
    do_read("unmapped_addr", 8'h10, 32'd0, 1'b1, 1'b1);
    do_read("not_selected",  8'h00, 32'd0, 1'b1, 1'b0);
    do_write(8'h08, 32'h3);
    do_read("final_status", 8'h08, 32'h0, 1'b0, 1'b1);

    repeat (2) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
